// File: rtl/cpu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fetch_pkg
//   Shared types and constants for the SimpleCPU instruction-fetch front end.
//   fetch_state_t : request / wait-for-response / hold-for-decode states
//   INSTR_BYTES   : size of one instruction word in bytes
//   WORD_SHIFT    : shift that turns a word offset into a byte offset
// ---------------------------------------------------------------------------
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam int unsigned WORD_SHIFT  = 2;

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
//   Combinational next-PC computation for the fetch unit.
//   pc      in  32  PC of the instruction being retired by decode
//   imm     in  32  sign-extended word offset (two's complement)
//   taken   in  1   branch taken for this instruction
//   next_pc out 32  pc + 4, or pc + 4 + imm*4 when taken (modulo 2^32)
// ---------------------------------------------------------------------------
module pc_next_calc
    import cpu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        taken,
    output logic [31:0] next_pc
);

    logic [31:0] offset;

    always_comb begin
        // Shifting within 32 bits drops the top two bits of the word offset.
        offset  = taken ? (imm << WORD_SHIFT) : '0;
        next_pc = pc + INSTR_BYTES + offset;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch front end: holds the architectural PC, issues one
//   instruction-memory read at a time, presents the fetched word to decode
//   and advances the PC on decode accept (sequential or taken branch).
//
//   Ports
//     clk, rst_n                      clock, synchronous active-low reset
//     imem_req_valid/ready, imem_addr read request channel (addr = pc)
//     imem_rsp_valid, imem_rsp_data   read response (1-cycle pulse)
//     inst_valid/ready, inst_out,     held instruction and its PC for decode
//     inst_pc
//     branch_taken, branch_imm        branch outcome, used only on accept
//   Optional (macro FETCH_PERF_EN defined)
//     fetch_count     accepts seen since reset
//     redirect_count  accepts with branch_taken since reset
//
//   Parameter RESET_PC : PC loaded on reset, must be 4-byte aligned.
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_out_q, inst_out_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  next_pc;
    logic         accept;

    pc_next_calc u_pc_next_calc (
        .pc      (inst_pc_q),
        .imm     (branch_imm),
        .taken   (branch_taken),
        .next_pc (next_pc)
    );

    // Decode handshake; branch inputs are meaningful only when this is high.
    assign accept = inst_valid_q && inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_out_d   = imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    inst_valid_d = 1'b0;
                    pc_d         = next_pc;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_out       = inst_out_q;
    assign inst_pc        = inst_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
            if (branch_taken) begin
                redirect_count_d = redirect_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Bench for pc_fetch_unit. Two instances share all inputs: one with
//   RESET_PC = 0 and one with RESET_PC = 0xFFFF_FFFC, so handshakes are
//   identical and only their PCs differ. Expected PCs come from plain
//   modulo-2^32 arithmetic on the architectural branch rule.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_imm = '0;

    logic        req_valid_a, inst_valid_a;
    logic [31:0] addr_a, inst_out_a, inst_pc_a;
    logic        req_valid_b, inst_valid_b;
    logic [31:0] addr_b, inst_out_b, inst_pc_b;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt_a, rcnt_a, fcnt_b, rcnt_b;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid_a),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (addr_a),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid_a),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out_a),
        .inst_pc        (inst_pc_a),
        .branch_taken   (branch_taken),
        .branch_imm     (branch_imm)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fcnt_a),
        .redirect_count (rcnt_a)
`endif
    );

    pc_fetch_unit #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid_b),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (addr_b),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid_b),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out_b),
        .inst_pc        (inst_pc_b),
        .branch_taken   (branch_taken),
        .branch_imm     (branch_imm)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fcnt_b),
        .redirect_count (rcnt_b)
`endif
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] m_pc, m_pc2, m_inst;
    int unsigned m_fetch, m_redir;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_perf();
`ifdef FETCH_PERF_EN
        chk("fetch_count", fcnt_a, m_fetch);
        chk("redirect_count", rcnt_a, m_redir);
        chk("fetch_count_wrap", fcnt_b, m_fetch);
`endif
    endtask

    // Assert reset for one edge, release it; leaves both DUTs requesting.
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        branch_taken   = 1'b0;
        tick();
        chk1("rst_inst_valid", inst_valid_a, 1'b0);
        chk1("rst_inst_valid_wrap", inst_valid_b, 1'b0);
        chk("rst_inst_out", inst_out_a, 32'h0);
        chk("rst_inst_pc", inst_pc_a, 32'h0);
        rst_n   = 1'b1;
        m_pc    = 32'h0;
        m_pc2   = WRAP_PC;
        m_fetch = 0;
        m_redir = 0;
        chk1("rst_req_valid", req_valid_a, 1'b1);
        chk("rst_addr", addr_a, m_pc);
        chk("rst_addr_wrap", addr_b, m_pc2);
        chk_perf();
    endtask

    // From the request state: stall the grant, then respond after a delay.
    task automatic do_fetch(input int req_wait, input int rsp_delay, input logic [31:0] data);
        for (int i = 0; i < req_wait; i++) begin
            chk1("req_hold_valid", req_valid_a, 1'b1);
            chk("req_hold_addr", addr_a, m_pc);
            imem_req_ready = 1'b0;
            imem_rsp_valid = (i == 0);   // stray response before grant
            imem_rsp_data  = ~data;
            tick();
            imem_rsp_valid = 1'b0;
        end
        chk1("req_valid", req_valid_a, 1'b1);
        chk("req_addr", addr_a, m_pc);
        chk("req_addr_wrap", addr_b, m_pc2);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            chk1("wait_req_valid", req_valid_a, 1'b0);
            chk1("wait_inst_valid", inst_valid_a, 1'b0);
            tick();
        end
        chk1("wait_req_valid", req_valid_a, 1'b0);
        chk1("wait_inst_valid", inst_valid_a, 1'b0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
        m_inst = data;
        chk1("hold_inst_valid", inst_valid_a, 1'b1);
        chk("hold_inst_out", inst_out_a, m_inst);
        chk("hold_inst_pc", inst_pc_a, m_pc);
        chk("hold_inst_pc_wrap", inst_pc_b, m_pc2);
        chk1("hold_req_valid", req_valid_a, 1'b0);
    endtask

    // From the hold state: stall decode, then accept with the given branch.
    task automatic do_accept(input int hold_wait, input logic taken, input logic [31:0] imm);
        for (int i = 0; i < hold_wait; i++) begin
            inst_ready     = 1'b0;
            branch_taken   = 1'($urandom_range(0, 1));
            branch_imm     = $urandom();
            imem_rsp_valid = (i == 1);   // stray response while holding
            imem_rsp_data  = ~m_inst;
            tick();
            imem_rsp_valid = 1'b0;
            chk1("stall_inst_valid", inst_valid_a, 1'b1);
            chk("stall_inst_out", inst_out_a, m_inst);
            chk("stall_inst_pc", inst_pc_a, m_pc);
            chk1("stall_req_valid", req_valid_a, 1'b0);
        end
        inst_ready   = 1'b1;
        branch_taken = taken;
        branch_imm   = imm;
        tick();
        inst_ready   = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = $urandom();
        m_pc  = m_pc  + 32'd4 + (taken ? imm * 32'd4 : 32'd0);
        m_pc2 = m_pc2 + 32'd4 + (taken ? imm * 32'd4 : 32'd0);
        m_fetch++;
        if (taken) m_redir++;
        chk1("acc_inst_valid", inst_valid_a, 1'b0);
        chk1("acc_req_valid", req_valid_a, 1'b1);
        chk("acc_addr", addr_a, m_pc);
        chk("acc_addr_wrap", addr_b, m_pc2);
        chk_perf();
    endtask

    initial begin
        tick();
        do_reset();

        // First fetch at 0, one-cycle response; wrap instance goes FFFF_FFFC -> 0
        do_fetch(0, 0, 32'hDEAD_0001);
        chk("first_inst_pc", inst_pc_a, 32'h0);
        do_accept(0, 1'b0, 32'h0);
        chk("wrap_to_zero", addr_b, 32'h0);

        do_fetch(0, 0, 32'hDEAD_0002);
        do_accept(0, 1'b1, 32'h0);            // 0x4 -> 0x8
        do_fetch(0, 0, 32'hDEAD_0003);
        do_accept(0, 1'b0, 32'h1234_5678);    // imm ignored when not taken
        chk("seq_addr_c", addr_a, 32'h0000_000C);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_3", fcnt_a, 32'd3);
        chk("perf_redirect_1", rcnt_a, 32'd1);
`endif
        do_fetch(0, 1, 32'hDEAD_0004);
        do_accept(0, 1'b1, 32'hFFFF_FFFE);    // 0xC -> 0x8
        do_fetch(0, 0, 32'hDEAD_0005);
        do_accept(0, 1'b1, 32'd3);            // 0x8 -> 0x18
        chk("branch_fwd", addr_a, 32'h0000_0018);
        do_fetch(0, 0, 32'hDEAD_0006);
        do_accept(0, 1'b1, 32'd1);            // 0x18 -> 0x20
        do_fetch(0, 0, 32'hDEAD_0007);
        do_accept(0, 1'b1, 32'hFFFF_FFFE);    // 0x20 -> 0x1C
        chk("branch_back", addr_a, 32'h0000_001C);

        // Backpressure on both channels, with stray responses
        do_fetch(5, 2, 32'hCAFE_0001);
        do_accept(4, 1'b0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            logic [31:0] imm;
            imm = (n % 4 == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
            do_accept($urandom_range(0, 3), 1'($urandom_range(0, 1)), imm);
        end

        // Reset while waiting for a response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk1("pre_rst_wait_req_valid", req_valid_a, 1'b0);
        do_reset();
        do_fetch(0, 0, 32'hBEEF_0001);
        do_accept(1, 1'b1, 32'd5);

        // Reset while holding an instruction
        do_fetch(0, 0, 32'hBEEF_0002);
        do_reset();
        do_fetch(1, 1, 32'hBEEF_0003);
        chk("post_rst_inst_pc", inst_pc_a, 32'h0);
        do_accept(0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
